// File: rtl/wb_write_port_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_write_port_if                                             |
// | Description : Result-source handshakes and register-file write port        |
// |               bundle for wb_write_port.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface wb_write_port_if #(
    parameter int XLEN = 64
);
    logic            alu_valid;
    logic            alu_ready;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_val;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      ld_offset;
    logic [1:0]      ld_size;
    logic            ld_unsigned;

    logic            write_sig;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_val;

    modport master (
        output alu_valid, alu_rd, alu_val,
        input  alu_ready,
        output ld_valid, ld_rd, ld_data, ld_offset, ld_size, ld_unsigned,
        input  ld_ready,
        input  write_sig, write_reg, write_val
    );

    modport slave (
        input  alu_valid, alu_rd, alu_val,
        output alu_ready,
        input  ld_valid, ld_rd, ld_data, ld_offset, ld_size, ld_unsigned,
        output ld_ready,
        output write_sig, write_reg, write_val
    );
endinterface
`default_nettype wire

// File: rtl/wb_write_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : wb_write_port                                                |
// | Description : Merges ALU and load results into an arrival-ordered FIFO     |
// |               and retires one register-file write per cycle. Optional      |
// |               forwarding lookup enabled by macro WB_FWD_EN.                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module wb_write_port #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  wire                      clk,
    input  wire                      reset,
    wb_write_port_if.slave           bus,
    output logic [$clog2(DEPTH):0]   occupancy
`ifdef WB_FWD_EN
    ,
    input  wire  [4:0]               fwd_query_rd,
    output logic                     fwd_valid,
    output logic [4:0]               fwd_reg,
    output logic [XLEN-1:0]          fwd_val
`endif
);
    localparam int c_AW = $clog2(DEPTH);
    localparam int c_OW = c_AW + 1;

    logic [4:0]      r_rd  [DEPTH];
    logic [XLEN-1:0] r_val [DEPTH];
    logic [c_AW-1:0] r_wp;
    logic [c_AW-1:0] r_rp;
    logic [c_OW-1:0] r_occ;
    logic            r_write_sig;
    logic [4:0]      r_write_reg;
    logic [XLEN-1:0] r_write_val;

    logic            w_ld_push;
    logic            w_alu_push;
    logic            w_pop;
    logic [1:0]      w_npush;
    logic [c_AW-1:0] w_wp_alu;
    logic [XLEN-1:0] w_ld_shift;
    logic [XLEN-1:0] w_ld_ext;

    // Space is judged from registered occupancy only; a same-cycle pop is not credited.
    assign bus.ld_ready  = (r_occ <= c_OW'(DEPTH - 1));
    assign bus.alu_ready = bus.ld_valid ? (r_occ <= c_OW'(DEPTH - 2))
                                        : (r_occ <= c_OW'(DEPTH - 1));

    assign w_ld_push  = bus.ld_valid  & bus.ld_ready;
    assign w_alu_push = bus.alu_valid & bus.alu_ready;
    assign w_pop      = (r_occ != '0);
    assign w_npush    = {1'b0, w_ld_push} + {1'b0, w_alu_push};
    assign w_wp_alu   = w_ld_push ? (r_wp + c_AW'(1)) : r_wp;

    assign w_ld_shift = bus.ld_data >> {bus.ld_offset, 3'b000};

    always_comb begin
        w_ld_ext = w_ld_shift;
        case (bus.ld_size)
            2'd0:    w_ld_ext = {{(XLEN-8){~bus.ld_unsigned & w_ld_shift[7]}},   w_ld_shift[7:0]};
            2'd1:    w_ld_ext = {{(XLEN-16){~bus.ld_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
            2'd2:    w_ld_ext = {{(XLEN-32){~bus.ld_unsigned & w_ld_shift[31]}}, w_ld_shift[31:0]};
            default: w_ld_ext = w_ld_shift;
        endcase
    end

    // Load entry takes the older slot when both sources push together.
    always_ff @(posedge clk) begin
        if (w_ld_push) begin
            r_rd[r_wp]  <= bus.ld_rd;
            r_val[r_wp] <= w_ld_ext;
        end
        if (w_alu_push) begin
            r_rd[w_wp_alu]  <= bus.alu_rd;
            r_val[w_wp_alu] <= bus.alu_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_occ       <= '0;
            r_write_sig <= 1'b0;
            r_write_reg <= '0;
            r_write_val <= '0;
        end else begin
            r_wp  <= r_wp + c_AW'(w_npush);
            r_occ <= r_occ + c_OW'(w_npush) - c_OW'(w_pop);
            if (w_pop) begin
                r_rp        <= r_rp + c_AW'(1);
                r_write_sig <= (r_rd[r_rp] != 5'd0);
                r_write_reg <= r_rd[r_rp];
                r_write_val <= (r_rd[r_rp] != 5'd0) ? r_val[r_rp] : '0;
            end else begin
                r_write_sig <= 1'b0;
            end
        end
    end

    assign bus.write_sig = r_write_sig;
    assign bus.write_reg = r_write_reg;
    assign bus.write_val = r_write_val;
    assign occupancy     = r_occ;

`ifdef WB_FWD_EN
    // Scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_reg   = '0;
        fwd_val   = '0;
        if (fwd_query_rd != 5'd0) begin
            if (r_write_sig && (r_write_reg == fwd_query_rd)) begin
                fwd_valid = 1'b1;
                fwd_reg   = r_write_reg;
                fwd_val   = r_write_val;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if ((c_OW'(i) < r_occ) && (r_rd[r_rp + c_AW'(i)] == fwd_query_rd)) begin
                    fwd_valid = 1'b1;
                    fwd_reg   = r_rd[r_rp + c_AW'(i)];
                    fwd_val   = r_val[r_rp + c_AW'(i)];
                end
            end
        end
    end
`endif
endmodule
`default_nettype wire

// File: tb/tb_wb_write_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_wb_write_port                                             |
// | Description : Self-checking bench for wb_write_port with a queue model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_wb_write_port;
    localparam int DEPTH = 4;
    localparam int XLEN  = 64;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [$clog2(DEPTH):0] occupancy;

    wb_write_port_if #(.XLEN(XLEN)) bus ();

    wb_write_port #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] val;
    } ent_t;

    ent_t        q[$];
    logic        exp_sig;
    logic [4:0]  exp_reg;
    logic [63:0] exp_val;
    logic [63:0] rf [32];
    int          checks = 0;
    int          errors = 0;
    bit          model_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] ld_ext(input logic [63:0] d, input int off, input int sz,
                                           input logic uns);
        logic [63:0] r;
        int          n;
        r = '0;
        n = 1 << sz;
        for (int b = 0; b < n; b++)
            if (off + b < 8) r[8*b +: 8] = d[8*(off+b) +: 8];
        if (!uns && sz < 3 && r[8*n-1])
            for (int k = 8*n; k < 64; k++) r[k] = 1'b1;
        return r;
    endfunction

    // Reference: a queue of pending writes, popped one per cycle.
    always @(posedge clk) begin : p_model
        int   n;
        bit   ldr;
        bit   alr;
        ent_t e;
        if (reset) begin
            q.delete();
            exp_sig = 1'b0;
            exp_reg = '0;
            exp_val = '0;
        end else begin
            n   = q.size();
            ldr = (n <= DEPTH - 1);
            alr = bus.ld_valid ? (n <= DEPTH - 2) : (n <= DEPTH - 1);
            if (n > 0) begin
                e       = q.pop_front();
                exp_sig = (e.rd != 5'd0);
                exp_reg = e.rd;
                exp_val = (e.rd != 5'd0) ? e.val : 64'd0;
            end else begin
                exp_sig = 1'b0;
            end
            if (bus.ld_valid && ldr)
                q.push_back('{rd: bus.ld_rd,
                              val: ld_ext(bus.ld_data, int'(bus.ld_offset), int'(bus.ld_size),
                                          bus.ld_unsigned)});
            if (bus.alu_valid && alr)
                q.push_back('{rd: bus.alu_rd, val: bus.alu_val});
        end
    end

    always @(posedge clk)
        if (!reset && bus.write_sig) rf[bus.write_reg] <= bus.write_val;

    always @(negedge clk) begin
        if (model_on) begin
            chk("write_sig", 64'(bus.write_sig), 64'(exp_sig));
            chk("write_reg", 64'(bus.write_reg), 64'(exp_reg));
            chk("write_val", bus.write_val, exp_val);
            chk("occupancy", 64'(occupancy), 64'(q.size()));
            chk("ld_ready", 64'(bus.ld_ready), 64'(q.size() <= DEPTH - 1));
            chk("alu_ready", 64'(bus.alu_ready),
                64'(bus.ld_valid ? (q.size() <= DEPTH - 2) : (q.size() <= DEPTH - 1)));
            chk("occ_bound", 64'(occupancy <= DEPTH), 64'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_val     = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_rd       = '0;
        bus.ld_data     = '0;
        bus.ld_offset   = '0;
        bus.ld_size     = '0;
        bus.ld_unsigned = 1'b0;
    endtask

    task automatic ld_case(input string nm, input logic [63:0] d, input logic [2:0] off,
                           input logic [1:0] sz, input logic u, input logic [63:0] expv);
        bus.ld_valid    = 1'b1;
        bus.ld_rd       = 5'd3;
        bus.ld_data     = d;
        bus.ld_offset   = off;
        bus.ld_size     = sz;
        bus.ld_unsigned = u;
        step();
        bus.ld_valid = 1'b0;
        step();
        @(negedge clk);
        chk(nm, bus.write_val, expv);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        model_on = 1'b1;
        reset    = 1'b0;

        chk("model_ld_byte_s", ld_ext(64'h8000, 1, 0, 1'b0), 64'hFFFF_FFFF_FFFF_FF80);
        chk("model_ld_half_s", ld_ext(64'h0000_0000_8001_0000, 2, 1, 1'b0), 64'hFFFF_FFFF_FFFF_8001);

        for (int i = 0; i < 5; i++) begin
            step();
            @(negedge clk);
            chk("idle_write_sig", 64'(bus.write_sig), 64'd0);
            chk("idle_occ", 64'(occupancy), 64'd0);
            chk("idle_alu_ready", 64'(bus.alu_ready), 64'd1);
            chk("idle_ld_ready", 64'(bus.ld_ready), 64'd1);
        end

        // Single ALU push: visible only after the second edge.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd5;
        bus.alu_val   = 64'h1234;
        step();
        bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("alu_not_early", 64'(bus.write_sig), 64'd0);
        chk("alu_occ1", 64'(occupancy), 64'd1);
        step();
        @(negedge clk);
        chk("alu_sig", 64'(bus.write_sig), 64'd1);
        chk("alu_reg", 64'(bus.write_reg), 64'd5);
        chk("alu_val", bus.write_val, 64'h1234);
        chk("alu_occ0", 64'(occupancy), 64'd0);
        step();
        @(negedge clk);
        chk("alu_sig_off", 64'(bus.write_sig), 64'd0);

        ld_case("ld_byte_signed",   64'h8000, 3'd1, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
        ld_case("ld_byte_unsigned", 64'h8000, 3'd1, 2'd0, 1'b1, 64'h80);
        ld_case("ld_double",        64'h8123_4567_89AB_CDEF, 3'd0, 2'd3, 1'b0, 64'h8123_4567_89AB_CDEF);
        ld_case("ld_half_signed",   64'h0000_0000_8001_0000, 3'd2, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8001);
        ld_case("ld_word_unsigned", 64'hDEAD_BEEF_0000_0000, 3'd4, 2'd2, 1'b1, 64'h0000_0000_DEAD_BEEF);
        ld_case("ld_word_signed",   64'hDEAD_BEEF_0000_0000, 3'd4, 2'd2, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);

        // Same-cycle tie: load first, then ALU; last write wins.
        bus.ld_valid    = 1'b1;
        bus.ld_rd       = 5'd7;
        bus.ld_data     = 64'hAAAA_0000_1111_2222;
        bus.ld_offset   = 3'd0;
        bus.ld_size     = 2'd3;
        bus.alu_valid   = 1'b1;
        bus.alu_rd      = 5'd7;
        bus.alu_val     = 64'hBBBB_3333_4444_5555;
        step();
        idle_inputs();
        step();
        @(negedge clk);
        chk("tie_first", bus.write_val, 64'hAAAA_0000_1111_2222);
        step();
        @(negedge clk);
        chk("tie_second", bus.write_val, 64'hBBBB_3333_4444_5555);
        step();
        @(negedge clk);
        chk("tie_rf_x7", rf[7], 64'hBBBB_3333_4444_5555);

        // Writes to x0 consume a slot without asserting the write.
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 5'd0;
        bus.alu_val   = 64'hDEAD;
        step();
        bus.alu_valid = 1'b0;
        step();
        @(negedge clk);
        chk("x0_sig", 64'(bus.write_sig), 64'd0);
        chk("x0_reg", 64'(bus.write_reg), 64'd0);
        chk("x0_val", bus.write_val, 64'd0);

        // Both sources valid every cycle: occupancy settles at DEPTH-1.
        bus.ld_valid  = 1'b1;
        bus.alu_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.ld_rd     = 5'($urandom_range(1, 31));
            bus.ld_data   = {$urandom, $urandom};
            bus.ld_size   = 2'd3;
            bus.ld_offset = 3'd0;
            bus.alu_rd    = 5'($urandom_range(1, 31));
            bus.alu_val   = {$urandom, $urandom};
            step();
        end
        @(negedge clk);
        chk("bp_occ", 64'(occupancy), 64'd3);
        chk("bp_alu_ready", 64'(bus.alu_ready), 64'd0);
        chk("bp_ld_ready", 64'(bus.ld_ready), 64'd1);

        // Reset with three entries queued discards them.
        reset = 1'b1;
        idle_inputs();
        step();
        @(negedge clk);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_sig", 64'(bus.write_sig), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk);
            chk("rst_no_write", 64'(bus.write_sig), 64'd0);
        end

        for (int c = 0; c < 3000; c++) begin
            int sz;
            int o;
            sz = $urandom_range(0, 3);
            o  = $urandom_range(0, 7);
            o  = o & ~((1 << sz) - 1);
            bus.alu_valid   = ($urandom_range(0, 99) < 55);
            bus.alu_rd      = 5'($urandom_range(0, 31));
            bus.alu_val     = {$urandom, $urandom};
            bus.ld_valid    = ($urandom_range(0, 99) < 55);
            bus.ld_rd       = 5'($urandom_range(0, 31));
            bus.ld_data     = {$urandom, $urandom};
            bus.ld_size     = 2'(sz);
            bus.ld_offset   = 3'(o);
            bus.ld_unsigned = 1'($urandom_range(0, 1));
            reset           = ($urandom_range(0, 299) == 0);
            step();
        end

        idle_inputs();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        @(negedge clk);
        chk("drain_occ", 64'(occupancy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
